vp_merge_layers: RTL and testbench

Parametrised layer compositor for the video pipeline. Takes LAYERS bitmap layers, each with a foreground colour, a background colour, a WIDTH-bit bitmap and an enable flag. Produces one colour per pixel, so lower layers show through transparent backgrounds. It sits between the text/graphic/sprite generators and the pixel serialiser. Per-layer visibility and transparency are set through a shadowed configuration that takes effect only at frame start.

---
 rtl/vp_merge_layers_pkg.sv | 48 ++++
 rtl/vp_merge_layers_if.sv | 33 +++
 rtl/vp_merge_layers_stage.sv | 84 ++++++++
 rtl/vp_merge_layers.sv | 103 ++++++++++
 tb/tb_vp_merge_layers.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/vp_merge_layers_pkg.sv
// Shared constants and the per-pixel merge rule for the layer compositor.
package vp_merge_layers_pkg;

    localparam int LAYERS_DEFAULT        = 2;
    localparam int WIDTH_DEFAULT         = 16;
    localparam int COLOR_BITS_DEFAULT    = 4;
    localparam int DEFAULT_COLOR_DEFAULT = 0;

    // Widest colour index the merge helper handles; callers zero-extend
    // their narrower colours into it and cast the result back down.
    localparam int MAX_COLOR_BITS = 16;
    typedef logic [MAX_COLOR_BITS-1:0] color_t;

    // Where a pixel's new colour comes from when a layer is applied.
    typedef enum logic [1:0] {
        SRC_KEEP = 2'd0,
        SRC_FG   = 2'd1,
        SRC_BG   = 2'd2
    } pix_src_e;

    function automatic pix_src_e pixel_source(input logic bit_set,
                                              input logic active,
                                              input logic transparent);
        pix_src_e src;
        src = SRC_KEEP;
        if (active) begin
            if (bit_set)           src = SRC_FG;
            else if (!transparent) src = SRC_BG;
        end
        return src;
    endfunction

    function automatic color_t merge_pixel(input color_t prev,
                                           input color_t fg,
                                           input color_t bg,
                                           input logic   bit_set,
                                           input logic   active,
                                           input logic   transparent);
        color_t res;
        case (pixel_source(bit_set, active, transparent))
            SRC_FG:  res = fg;
            SRC_BG:  res = bg;
            default: res = prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vp_merge_layers_if.sv
// Word-level bus of the compositor: layer inputs, config strobes, merged output.
interface vp_merge_layers_if
    import vp_merge_layers_pkg::*;
#(
    parameter int LAYERS     = LAYERS_DEFAULT,
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int COLOR_BITS = COLOR_BITS_DEFAULT
);
    logic                         in_valid;
    logic [LAYERS*COLOR_BITS-1:0] lay_foreground;
    logic [LAYERS*COLOR_BITS-1:0] lay_background;
    logic [LAYERS*WIDTH-1:0]      lay_bitmap;
    logic [LAYERS-1:0]            lay_enabled;
    logic                         cfg_write;
    logic [LAYERS-1:0]            cfg_visible;
    logic [LAYERS-1:0]            cfg_transparent;
    logic                         frame_start;
    logic                         out_valid;
    logic [WIDTH*COLOR_BITS-1:0]  out_pixels;
    logic                         out_enable;

    modport master (
        output in_valid, lay_foreground, lay_background, lay_bitmap, lay_enabled,
        output cfg_write, cfg_visible, cfg_transparent, frame_start,
        input  out_valid, out_pixels, out_enable
    );

    modport slave (
        input  in_valid, lay_foreground, lay_background, lay_bitmap, lay_enabled,
        input  cfg_write, cfg_visible, cfg_transparent, frame_start,
        output out_valid, out_pixels, out_enable
    );
endinterface

// File: rtl/vp_merge_layers_stage.sv
// One compositor stage: applies layer IDX to the running pixel word and
// registers it together with the word's valid, enable flag, config and layer data.
module vp_merge_stage
    import vp_merge_layers_pkg::*;
#(
    parameter int LAYERS        = LAYERS_DEFAULT,
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int COLOR_BITS    = COLOR_BITS_DEFAULT,
    parameter int DEFAULT_COLOR = DEFAULT_COLOR_DEFAULT,
    parameter int IDX           = 0
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_valid,
    input  logic                         i_enable,
    input  logic [WIDTH*COLOR_BITS-1:0]  i_pixels,
    input  logic [LAYERS-1:0]            i_vis,
    input  logic [LAYERS-1:0]            i_trn,
    input  logic [LAYERS-1:0]            i_lay_en,
    input  logic [LAYERS*COLOR_BITS-1:0] i_fg,
    input  logic [LAYERS*COLOR_BITS-1:0] i_bg,
    input  logic [LAYERS*WIDTH-1:0]      i_bitmap,
    output logic                         o_valid,
    output logic                         o_enable,
    output logic [WIDTH*COLOR_BITS-1:0]  o_pixels,
    output logic [LAYERS-1:0]            o_vis,
    output logic [LAYERS-1:0]            o_trn,
    output logic [LAYERS-1:0]            o_lay_en,
    output logic [LAYERS*COLOR_BITS-1:0] o_fg,
    output logic [LAYERS*COLOR_BITS-1:0] o_bg,
    output logic [LAYERS*WIDTH-1:0]      o_bitmap
);
    localparam logic [COLOR_BITS-1:0] DEF_C = COLOR_BITS'(DEFAULT_COLOR);

    logic                        w_active;
    logic [COLOR_BITS-1:0]       w_fg;
    logic [COLOR_BITS-1:0]       w_bg;
    logic [WIDTH-1:0]            w_bits;
    logic [WIDTH*COLOR_BITS-1:0] w_pixels;

    assign w_active = i_lay_en[IDX] & i_vis[IDX];
    assign w_fg     = i_fg[IDX*COLOR_BITS +: COLOR_BITS];
    assign w_bg     = i_bg[IDX*COLOR_BITS +: COLOR_BITS];
    assign w_bits   = i_bitmap[IDX*WIDTH +: WIDTH];

    // Pixel slot j lines up with bitmap bit j (both have the leftmost pixel on top).
    always_comb begin
        w_pixels = i_pixels;
        for (int j = 0; j < WIDTH; j++) begin
            w_pixels[j*COLOR_BITS +: COLOR_BITS] = COLOR_BITS'(merge_pixel(
                color_t'(i_pixels[j*COLOR_BITS +: COLOR_BITS]),
                color_t'(w_fg), color_t'(w_bg),
                w_bits[j], w_active, i_trn[IDX]));
        end
    end

    // Stage register; bubbles only advance the valid bit so data holds still.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid  <= 1'b0;
            o_enable <= 1'b0;
            o_pixels <= {WIDTH{DEF_C}};
            o_vis    <= '1;
            o_trn    <= '0;
            o_lay_en <= '0;
            o_fg     <= '0;
            o_bg     <= '0;
            o_bitmap <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_enable <= i_enable | w_active;
                o_pixels <= w_pixels;
                o_vis    <= i_vis;
                o_trn    <= i_trn;
                o_lay_en <= i_lay_en;
                o_fg     <= i_fg;
                o_bg     <= i_bg;
                o_bitmap <= i_bitmap;
            end
        end
    end

endmodule

// File: rtl/vp_merge_layers.sv
// Layer compositor top: shadow/active visibility+transparency config and a
// chain of LAYERS merge stages, lowest-priority layer first.
module vp_merge_layers
    import vp_merge_layers_pkg::*;
#(
    parameter int LAYERS        = LAYERS_DEFAULT,
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int COLOR_BITS    = COLOR_BITS_DEFAULT,
    parameter int DEFAULT_COLOR = DEFAULT_COLOR_DEFAULT
)(
    input  logic              clk,
    input  logic              reset,
    vp_merge_layers_if.slave  bus
);
    localparam logic [COLOR_BITS-1:0] DEF_C = COLOR_BITS'(DEFAULT_COLOR);

    logic [LAYERS-1:0] r_shd_vis, r_shd_trn;
    logic [LAYERS-1:0] r_act_vis, r_act_trn;

    // Index k is the input of stage k; index LAYERS is the pipeline output.
    logic                         w_valid  [LAYERS+1];
    logic                         w_enable [LAYERS+1];
    logic [WIDTH*COLOR_BITS-1:0]  w_pixels [LAYERS+1];
    logic [LAYERS-1:0]            w_vis    [LAYERS+1];
    logic [LAYERS-1:0]            w_trn    [LAYERS+1];
    logic [LAYERS-1:0]            w_lay_en [LAYERS+1];
    logic [LAYERS*COLOR_BITS-1:0] w_fg     [LAYERS+1];
    logic [LAYERS*COLOR_BITS-1:0] w_bg     [LAYERS+1];
    logic [LAYERS*WIDTH-1:0]      w_bitmap [LAYERS+1];

    // Shadow/active config; a write coinciding with frame start goes straight to active.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shd_vis <= '1;
            r_shd_trn <= '0;
            r_act_vis <= '1;
            r_act_trn <= '0;
        end else begin
            if (bus.cfg_write) begin
                r_shd_vis <= bus.cfg_visible;
                r_shd_trn <= bus.cfg_transparent;
            end
            if (bus.frame_start) begin
                r_act_vis <= bus.cfg_write ? bus.cfg_visible     : r_shd_vis;
                r_act_trn <= bus.cfg_write ? bus.cfg_transparent : r_shd_trn;
            end
        end
    end

    // A word picks up the active config on entry and carries it to the end.
    assign w_valid[0]  = bus.in_valid;
    assign w_enable[0] = 1'b0;
    assign w_pixels[0] = {WIDTH{DEF_C}};
    assign w_vis[0]    = r_act_vis;
    assign w_trn[0]    = r_act_trn;
    assign w_lay_en[0] = bus.lay_enabled;
    assign w_fg[0]     = bus.lay_foreground;
    assign w_bg[0]     = bus.lay_background;
    assign w_bitmap[0] = bus.lay_bitmap;

    generate
        for (genvar k = 0; k < LAYERS; k++) begin : g_stage
            vp_merge_stage #(
                .LAYERS        (LAYERS),
                .WIDTH         (WIDTH),
                .COLOR_BITS    (COLOR_BITS),
                .DEFAULT_COLOR (DEFAULT_COLOR),
                .IDX           (k)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .i_valid  (w_valid[k]),
                .i_enable (w_enable[k]),
                .i_pixels (w_pixels[k]),
                .i_vis    (w_vis[k]),
                .i_trn    (w_trn[k]),
                .i_lay_en (w_lay_en[k]),
                .i_fg     (w_fg[k]),
                .i_bg     (w_bg[k]),
                .i_bitmap (w_bitmap[k]),
                .o_valid  (w_valid[k+1]),
                .o_enable (w_enable[k+1]),
                .o_pixels (w_pixels[k+1]),
                .o_vis    (w_vis[k+1]),
                .o_trn    (w_trn[k+1]),
                .o_lay_en (w_lay_en[k+1]),
                .o_fg     (w_fg[k+1]),
                .o_bg     (w_bg[k+1]),
                .o_bitmap (w_bitmap[k+1])
            );
        end
    endgenerate

    assign bus.out_valid  = w_valid[LAYERS];
    assign bus.out_enable = w_enable[LAYERS];
    assign bus.out_pixels = w_pixels[LAYERS];

    // Layer data and config leaving the last stage have no consumer.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_vis[LAYERS], w_trn[LAYERS], w_lay_en[LAYERS],
                             w_fg[LAYERS], w_bg[LAYERS], w_bitmap[LAYERS]};

endmodule

// File: tb/tb_vp_merge_layers.sv
// Bench for vp_merge_layers: a 4-layer and a 2-layer instance share one
// stimulus stream and are checked every cycle against a reference model.
module tb_vp_merge_layers;

    localparam logic [3:0] DEF2 = 4'h0;
    localparam logic [3:0] DEF4 = 4'hE;
    localparam int HMAX = 2048;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vp_merge_layers_if #(.LAYERS(4), .WIDTH(16), .COLOR_BITS(4)) if4();
    vp_merge_layers_if #(.LAYERS(2), .WIDTH(16), .COLOR_BITS(4)) if2();

    vp_merge_layers #(.LAYERS(4), .WIDTH(16), .COLOR_BITS(4), .DEFAULT_COLOR(14))
        dut4 (.clk(clk), .reset(reset), .bus(if4));
    vp_merge_layers #(.LAYERS(2), .WIDTH(16), .COLOR_BITS(4), .DEFAULT_COLOR(0))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    // The 2-layer instance sees layers 0 and 1 of the same stimulus.
    assign if2.in_valid        = if4.in_valid;
    assign if2.lay_foreground  = if4.lay_foreground[7:0];
    assign if2.lay_background  = if4.lay_background[7:0];
    assign if2.lay_bitmap      = if4.lay_bitmap[31:0];
    assign if2.lay_enabled     = if4.lay_enabled[1:0];
    assign if2.cfg_write       = if4.cfg_write;
    assign if2.cfg_visible     = if4.cfg_visible[1:0];
    assign if2.cfg_transparent = if4.cfg_transparent[1:0];
    assign if2.frame_start     = if4.frame_start;

    typedef struct packed {
        logic             rst;
        logic             valid;
        logic             cfg_write;
        logic             frame_start;
        logic [3:0]       cfg_vis;
        logic [3:0]       cfg_trn;
        logic [3:0]       en;
        logic [3:0]       vis;   // active config seen by this word (model)
        logic [3:0]       trn;
        logic [3:0][3:0]  fg;
        logic [3:0][3:0]  bg;
        logic [3:0][15:0] bmp;
        logic             pin_on;
        logic [63:0]      pin2;
        logic [63:0]      pin4;
    } word_t;

    word_t      hist [HMAX];
    word_t      cur;
    int         cyc;
    int         checks;
    int         errors;
    logic [3:0] m_shd_vis, m_shd_trn, m_act_vis, m_act_trn;

    // Each pixel shows the topmost active layer that claims it (set bit, or
    // opaque background); unclaimed pixels show the default colour.
    function automatic void model(input int L, input logic [3:0] def, input word_t w,
                                  output logic [63:0] pix, output logic en);
        logic [3:0] c;
        logic       done;
        en = 1'b0;
        for (int k = 0; k < L; k++) if (w.en[k] && w.vis[k]) en = 1'b1;
        for (int p = 0; p < 16; p++) begin
            c    = def;
            done = 1'b0;
            for (int k = L - 1; k >= 0; k--) begin
                if (!done && w.en[k] && w.vis[k]) begin
                    if (w.bmp[k][15-p]) begin
                        c = w.fg[k]; done = 1'b1;
                    end else if (!w.trn[k]) begin
                        c = w.bg[k]; done = 1'b1;
                    end
                end
            end
            pix[(15-p)*4 +: 4] = c;
        end
    endfunction

    task automatic cmp(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, d, act, exp);
        end
    endtask

    task automatic check_one(input string nm, input int L, input logic [3:0] def, input int d,
                             input logic av, input logic [63:0] ap, input logic ae);
        logic        ev;
        logic        ee;
        logic [63:0] ep;
        word_t       w;
        ev = (d - L >= 0) ? hist[d-L].valid : 1'b0;
        for (int j = (d - L < 0 ? 0 : d - L); j < d; j++) if (hist[j].rst) ev = 1'b0;
        cmp({nm, "_valid"}, d, 64'(av), 64'(ev));
        if (hist[d-1].rst) begin
            cmp({nm, "_rst_pixels"}, d, ap, {16{def}});
            cmp({nm, "_rst_enable"}, d, 64'(ae), 64'(0));
        end else if (ev) begin
            w = hist[d-L];
            model(L, def, w, ep, ee);
            cmp({nm, "_pixels"}, d, ap, ep);
            cmp({nm, "_enable"}, d, 64'(ae), 64'(ee));
            if (w.pin_on) cmp({nm, "_literal"}, d, ap, (L == 2) ? w.pin2 : w.pin4);
        end
    endtask

    // Drive one cycle of stimulus, advance the model config, check both outputs.
    task automatic tick();
        word_t w;
        w     = cur;
        w.vis = m_act_vis;
        w.trn = m_act_trn;
        reset                  = w.rst;
        if4.in_valid           = w.valid;
        if4.lay_foreground     = w.fg;
        if4.lay_background     = w.bg;
        if4.lay_bitmap         = w.bmp;
        if4.lay_enabled        = w.en;
        if4.cfg_write          = w.cfg_write;
        if4.cfg_visible        = w.cfg_vis;
        if4.cfg_transparent    = w.cfg_trn;
        if4.frame_start        = w.frame_start;
        hist[cyc] = w;
        @(posedge clk);
        if (w.rst) begin
            m_shd_vis = 4'hF; m_shd_trn = 4'h0;
            m_act_vis = 4'hF; m_act_trn = 4'h0;
        end else begin
            if (w.frame_start) begin
                m_act_vis = w.cfg_write ? w.cfg_vis : m_shd_vis;
                m_act_trn = w.cfg_write ? w.cfg_trn : m_shd_trn;
            end
            if (w.cfg_write) begin
                m_shd_vis = w.cfg_vis;
                m_shd_trn = w.cfg_trn;
            end
        end
        cyc++;
        #1;
        check_one("L4", 4, DEF4, cyc, if4.out_valid, if4.out_pixels, if4.out_enable);
        check_one("L2", 2, DEF2, cyc, if2.out_valid, if2.out_pixels, if2.out_enable);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        m_shd_vis = 4'hF; m_shd_trn = 4'h0; m_act_vis = 4'hF; m_act_trn = 4'h0;
        cur = '0;
        cur.rst = 1'b1;
        tick(); tick();
        cur.rst = 1'b0;

        // Legacy text-only word; layers 2/3 off so both instances agree.
        cur.valid = 1'b1; cur.en = 4'b0001;
        cur.fg[0] = 4'h3; cur.bg[0] = 4'h1; cur.bmp[0] = 16'hF000;
        cur.pin_on = 1'b1;
        cur.pin2 = 64'h3333_1111_1111_1111; cur.pin4 = cur.pin2;
        tick();

        // Opaque graphics override.
        cur.en = 4'b0011; cur.fg[1] = 4'h9; cur.bg[1] = 4'h2; cur.bmp[1] = 16'h0001;
        cur.pin2 = 64'h2222_2222_2222_2229; cur.pin4 = cur.pin2;
        tick();

        // Graphics background transparent, written and activated together.
        cur.valid = 1'b0; cur.pin_on = 1'b0;
        cur.cfg_write = 1'b1; cur.frame_start = 1'b1;
        cur.cfg_vis = 4'hF; cur.cfg_trn = 4'b0010;
        tick();
        cur.cfg_write = 1'b0; cur.frame_start = 1'b0;
        cur.valid = 1'b1; cur.pin_on = 1'b1;
        cur.pin2 = 64'h3333_1111_1111_1119; cur.pin4 = cur.pin2;
        tick();

        // Hide graphics in the shadow only: nothing changes until frame start.
        cur.cfg_write = 1'b1; cur.cfg_vis = 4'b1101; cur.cfg_trn = 4'b0010;
        tick();
        cur.cfg_write = 1'b0;
        repeat (10) tick();
        cur.frame_start = 1'b1;
        tick();
        cur.frame_start = 1'b0;
        cur.pin2 = 64'h3333_1111_1111_1111; cur.pin4 = cur.pin2;
        repeat (3) tick();

        // All four layers enabled and opaque, back-to-back words.
        cur.en = 4'b1111;
        cur.fg[2] = 4'hC; cur.bg[2] = 4'h6; cur.bmp[2] = 16'h0F0F;
        cur.fg[3] = 4'hA; cur.bg[3] = 4'h5; cur.bmp[3] = 16'hFF00;
        cur.cfg_write = 1'b1; cur.frame_start = 1'b1;
        cur.cfg_vis = 4'hF; cur.cfg_trn = 4'h0; cur.pin_on = 1'b0;
        tick();
        cur.cfg_write = 1'b0; cur.frame_start = 1'b0; cur.pin_on = 1'b1;
        cur.pin4 = 64'hAAAA_AAAA_5555_5555; cur.pin2 = 64'h2222_2222_2222_2229;
        repeat (6) tick();
        cur.cfg_write = 1'b1; cur.frame_start = 1'b1; cur.cfg_vis = 4'b0111;
        cur.pin_on = 1'b0;
        tick();
        cur.cfg_write = 1'b0; cur.frame_start = 1'b0; cur.pin_on = 1'b1;
        cur.pin4 = 64'h6666_CCCC_6666_CCCC;
        repeat (6) tick();

        // Reset with words in flight.
        cur.pin_on = 1'b0;
        tick(); tick();
        cur.rst = 1'b1;
        tick();
        cur.rst = 1'b0; cur.valid = 1'b0;
        repeat (6) tick();

        // Randomized traffic with config changes and occasional resets.
        repeat (800) begin
            cur = '0;
            cur.rst         = ($urandom_range(0, 99) == 0);
            cur.valid       = ($urandom_range(0, 9) < 7);
            cur.cfg_write   = ($urandom_range(0, 7) == 0);
            cur.frame_start = ($urandom_range(0, 7) == 0);
            cur.cfg_vis     = 4'($urandom);
            cur.cfg_trn     = 4'($urandom);
            cur.en          = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                cur.fg[k]  = 4'($urandom);
                cur.bg[k]  = 4'($urandom);
                cur.bmp[k] = 16'($urandom);
            end
            tick();
        end

        cur = '0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
